// File: rtl/inst_refill.sv
// Instruction-cache refill engine: reads the four bytes of a missing instruction
// from the byte-wide memory port and writes the assembled word into the cache.
module inst_refill #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rdy_i,
  input  logic                  miss_i,
  input  logic [ADDR_WIDTH-1:0] miss_pc_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_valid_i,
  input  logic [7:0]            mem_data_i,
  output logic                  cache_we_o,
  output logic [ADDR_WIDTH-1:0] cache_pc_o,
  output logic [INST_WIDTH-1:0] cache_inst_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  // rdy_i low holds every register, so outputs simply reflect the frozen state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      base_q  <= '0;
      inst_q  <= '0;
    end else if (rdy_i) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    inst_d       = inst_q;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    cache_we_o   = 1'b0;
    cache_pc_o   = '0;
    cache_inst_o = '0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (miss_i && !flush_i) begin
          base_d  = miss_pc_i;
          idx_d   = 2'd0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = base_q + ADDR_WIDTH'(idx_q);
        if (flush_i) begin
          // A granted request still owes us a byte, which must be drained.
          state_d = mem_gnt_i ? S_DRAIN : S_IDLE;
        end else if (mem_gnt_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_valid_i) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            inst_d[{idx_q, 3'b000} +: 8] = mem_data_i;
            if (idx_q == 2'd3) begin
              state_d = S_WRITE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_REQ;
            end
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end

      // The assembled word is valid for base regardless of a flush.
      S_WRITE: begin
        cache_we_o   = 1'b1;
        done_o       = 1'b1;
        cache_pc_o   = base_q;
        cache_inst_o = inst_q;
        state_d      = S_IDLE;
      end

      S_DRAIN: begin
        if (mem_valid_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_inst_refill.sv
// Bench for inst_refill: table vectors, hand-written flush/reset sequences and
// randomized refills checked against an arithmetic reference model.
module tb_inst_refill;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rdy_i;
  logic        miss_i;
  logic [31:0] miss_pc_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_valid_i;
  logic [7:0]  mem_data_i;
  logic        cache_we_o;
  logic [31:0] cache_pc_o;
  logic [31:0] cache_inst_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int failures = 0;
  int we_seen = 0;

  inst_refill #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rdy_i       (rdy_i),
    .miss_i      (miss_i),
    .miss_pc_i   (miss_pc_i),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_i  (mem_data_i),
    .cache_we_o  (cache_we_o),
    .cache_pc_o  (cache_pc_o),
    .cache_inst_o(cache_inst_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (cache_we_o) we_seen <= we_seen + 1;
  end

  // Per-byte grant delay / data delay are in cycles beyond the minimum.
  typedef struct {
    logic [31:0]      pc;
    logic [3:0][7:0]  bytes;
    logic [3:0][3:0]  gdly;
    logic [3:0][3:0]  ddly;
    int               stall_at;
    int               stall_len;
    bit               flush_wr;
    logic [31:0]      exp_word;
    int               exp_cyc;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] bytes,
                              input logic [15:0] gd, input logic [15:0] dd,
                              input int sa, input int sl, input bit fw,
                              input logic [31:0] ew, input int ec);
    vec_t v;
    v.pc = pc; v.bytes = bytes; v.gdly = gd; v.ddly = dd;
    v.stall_at = sa; v.stall_len = sl; v.flush_wr = fw;
    v.exp_word = ew; v.exp_cyc = ec;
    return v;
  endfunction

  // Write cycle = miss cycle + stall + per byte (grant wait + data wait + 2).
  function automatic int model_cycles(input logic [15:0] gd, input logic [15:0] dd, input int sl);
    int n = 1 + sl;
    for (int i = 0; i < 4; i++) n += int'(gd[4*i +: 4]) + int'(dd[4*i +: 4]) + 2;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus();
    mem_gnt_i   = 1'b0;
    mem_valid_i = 1'b0;
    flush_i     = 1'b0;
    rdy_i       = 1'b1;
    mem_data_i  = 8'($urandom);
  endtask

  task automatic check_output(input string name, input bit busy, input bit req);
    check({name, "_busy"}, 64'(busy_o), 64'(busy));
    check({name, "_req"}, 64'(mem_req_o), 64'(req));
    check({name, "_we"}, 64'(cache_we_o), 64'd0);
  endtask

  // Plays fetch stage and memory controller for one complete refill.
  task automatic run_refill(input vec_t v);
    int  byte_n = 0;
    int  cnt = 0;
    int  writes = 0;
    bit  in_wait = 1'b0;
    bit  finished = 1'b0;
    apply_stimulus();
    miss_i    = 1'b1;
    miss_pc_i = v.pc;
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      @(negedge clk_i);
      apply_stimulus();
      miss_pc_i = $urandom & 32'hFFFF_FFFC;
      if (writes > 0) begin
        check("post_busy", 64'(busy_o), 64'd0);
        check("post_we", 64'(cache_we_o), 64'd0);
        finished = 1'b1;
      end else if (cache_we_o) begin
        writes++;
        check("wr_cycle", 64'(cyc), 64'(v.exp_cyc));
        check("wr_done", 64'(done_o), 64'd1);
        check("wr_pc", 64'(cache_pc_o), 64'(v.pc));
        check("wr_inst", 64'(cache_inst_o), 64'(v.exp_word));
        check("wr_bytes", 64'(byte_n), 64'd4);
        miss_i  = 1'b0;
        flush_i = v.flush_wr;
      end else begin
        check("busy", 64'(busy_o), 64'd1);
        if (!busy_o) begin
          finished = 1'b1;
        end else if (cyc >= v.stall_at && cyc < v.stall_at + v.stall_len) begin
          rdy_i = 1'b0;
        end else if (byte_n < 4) begin
          if (!in_wait) begin
            check("req", 64'(mem_req_o), 64'd1);
            check("req_addr", 64'(mem_addr_o), 64'(32'(v.pc + 32'(byte_n))));
            if (cnt == int'(v.gdly[byte_n])) begin
              mem_gnt_i = 1'b1; in_wait = 1'b1; cnt = 0;
            end else cnt++;
          end else begin
            check("wait_req", 64'(mem_req_o), 64'd0);
            if (cnt == int'(v.ddly[byte_n])) begin
              mem_valid_i = 1'b1; mem_data_i = v.bytes[byte_n];
              byte_n++; in_wait = 1'b0; cnt = 0;
            end else cnt++;
          end
        end
      end
    end
    if (!finished) begin
      failures++;
      $display("[TB] FAIL refill_timeout pc=%0h did not complete within 200 cycles", v.pc);
    end
    miss_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not terminate");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int   snap;
    logic [15:0] gd, dd;
    int   sl;

    rst_i = 1'b0; miss_i = 1'b0; miss_pc_i = '0;
    apply_stimulus();

    vecs[0] = mk(32'h0000_1004, 32'h0010_0513, 16'h0000, 16'h0000, 0, 0, 1'b0, 32'h0010_0513, 9);
    vecs[1] = mk(32'h0000_3008, 32'hDDCC_BBAA, 16'h0300, 16'h0002, 0, 0, 1'b0, 32'hDDCC_BBAA, 14);
    vecs[2] = mk(32'h4000_0010, 32'h0403_0201, 16'h0000, 16'h0000, 3, 4, 1'b0, 32'h0403_0201, 13);
    vecs[3] = mk(32'hFFFF_FFFC, 32'hDEAD_BEEF, 16'h1001, 16'h0010, 0, 0, 1'b0, 32'hDEAD_BEEF, 12);
    vecs[4] = mk(32'h0000_0040, 32'hCAFE_F00D, 16'h0000, 16'h0000, 0, 0, 1'b1, 32'hCAFE_F00D, 9);

    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_we", 64'(cache_we_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_pc", 64'(cache_pc_o), 64'd0);
    check("rst_inst", 64'(cache_inst_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) run_refill(vecs[i]);

    $display("[TB] flush during WAIT of byte 1, late byte drained");
    snap = we_seen;
    apply_stimulus(); miss_i = 1'b1; miss_pc_i = 32'h0000_5000;
    @(negedge clk_i); apply_stimulus();
    check("fa_addr0", 64'(mem_addr_o), 64'h5000); mem_gnt_i = 1'b1;
    @(negedge clk_i); apply_stimulus(); mem_valid_i = 1'b1; mem_data_i = 8'h11;
    @(negedge clk_i); apply_stimulus();
    check("fa_addr1", 64'(mem_addr_o), 64'h5001); mem_gnt_i = 1'b1;
    @(negedge clk_i); apply_stimulus(); flush_i = 1'b1; miss_i = 1'b0;
    @(negedge clk_i); apply_stimulus(); check_output("fa_drain", 1'b1, 1'b0);
    @(negedge clk_i); apply_stimulus(); check_output("fa_late", 1'b1, 1'b0);
    mem_valid_i = 1'b1; mem_data_i = 8'h22;
    @(negedge clk_i); apply_stimulus(); check_output("fa_idle", 1'b0, 1'b0);
    check("fa_no_write", 64'(we_seen), 64'(snap));
    run_refill(mk(32'h0000_2000, 32'h0010_0093, 16'h0000, 16'h0000, 0, 0, 1'b0, 32'h0010_0093, 9));

    $display("[TB] flush paths");
    snap = we_seen;
    apply_stimulus(); miss_i = 1'b1; miss_pc_i = 32'h0000_6000;
    @(negedge clk_i); apply_stimulus(); check_output("fr_req", 1'b1, 1'b1);
    flush_i = 1'b1; miss_i = 1'b0;
    @(negedge clk_i); apply_stimulus(); check_output("fr_idle", 1'b0, 1'b0);
    miss_i = 1'b1; miss_pc_i = 32'h0000_6100;
    @(negedge clk_i); apply_stimulus(); flush_i = 1'b1; mem_gnt_i = 1'b1; miss_i = 1'b0;
    @(negedge clk_i); apply_stimulus(); check_output("fg_drain", 1'b1, 1'b0);
    mem_valid_i = 1'b1;
    @(negedge clk_i); apply_stimulus(); check_output("fg_idle", 1'b0, 1'b0);
    miss_i = 1'b1; miss_pc_i = 32'h0000_7000;
    @(negedge clk_i); apply_stimulus(); mem_gnt_i = 1'b1;
    @(negedge clk_i); apply_stimulus(); mem_valid_i = 1'b1; flush_i = 1'b1; miss_i = 1'b0;
    @(negedge clk_i); apply_stimulus(); check_output("fv_idle", 1'b0, 1'b0);
    check("flush_no_write", 64'(we_seen), 64'(snap));

    $display("[TB] asynchronous reset mid-WAIT");
    snap = we_seen;
    miss_i = 1'b1; miss_pc_i = 32'h0000_8000;
    @(negedge clk_i); apply_stimulus(); mem_gnt_i = 1'b1;
    @(negedge clk_i); apply_stimulus(); check_output("ar_wait", 1'b1, 1'b0);
    #2 rst_i = 1'b0;
    #1 check_output("ar_async", 1'b0, 1'b0);
    check("ar_addr", 64'(mem_addr_o), 64'd0);
    @(negedge clk_i); rst_i = 1'b1; miss_i = 1'b0; apply_stimulus();
    @(negedge clk_i); apply_stimulus(); mem_valid_i = 1'b1; mem_data_i = 8'h77;
    @(negedge clk_i); apply_stimulus(); check_output("ar_stray", 1'b0, 1'b0);
    @(negedge clk_i); check("ar_no_write", 64'(we_seen), 64'(snap));

    $display("[TB] randomized refills");
    for (int r = 0; r < 24; r++) begin
      gd = '0; dd = '0;
      for (int i = 0; i < 4; i++) begin
        gd[4*i +: 4] = 4'($urandom_range(0, 3));
        dd[4*i +: 4] = 4'($urandom_range(0, 3));
      end
      sl = int'($urandom_range(0, 4));
      v = mk($urandom & 32'hFFFF_FFFC, $urandom, gd, dd, int'($urandom_range(1, 4)), sl,
             1'($urandom_range(0, 1)), 32'h0, 0);
      v.exp_word = {v.bytes[3], v.bytes[2], v.bytes[1], v.bytes[0]};
      v.exp_cyc  = model_cycles(gd, dd, sl);
      run_refill(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
